// File: rtl/pio_svc_pkg.sv
// Shared types and PIO register offsets for the PIO event servicer.
package pio_svc_pkg;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StRdEdge,
        StChk,
        StRdData,
        StCap,
        StEmit
    } svc_state_e;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE    = 2'd3;

endpackage

// File: rtl/pio_poll_timer.sv
// Idle-time poll counter: ticks once every POLL_CYCLES enabled cycles.
module pio_poll_timer #(
    parameter int unsigned POLL_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = (POLL_CYCLES > 0) ? CntW'(POLL_CYCLES - 1) : '0;

    logic [CntW-1:0] cnt_d, cnt_q;

    // Next count: clear has priority; wrap after the tick so polls stay periodic.
    always_comb begin
        cnt_d = cnt_q;
        if (POLL_CYCLES == 0 || clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (POLL_CYCLES != 0) && en_i && (cnt_q == CntMax);

endmodule

// File: rtl/pio_event_servicer.sv
// Avalon-MM master that programs the button PIO, then reads and clears its
// edge-capture register on irq or poll tick and emits each capture as an event.
module pio_event_servicer
    import pio_svc_pkg::*;
#(
    parameter int unsigned      WIDTH         = 4,
    parameter logic [WIDTH-1:0] IRQ_MASK_INIT = 4'hF,
    parameter int unsigned      POLL_CYCLES   = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       address,
    output logic             chipselect,
    output logic             write_n,
    output logic [31:0]      writedata,
    input  logic [31:0]      readdata,
    input  logic             irq,
    output logic             event_valid,
    input  logic             event_ready,
    output logic [WIDTH-1:0] event_edges,
    output logic [WIDTH-1:0] event_level
);

    svc_state_e       state_d, state_q;
    logic             cs_d, cs_q;
    logic             wen_d, wen_q;
    logic [1:0]       addr_d, addr_q;
    logic [31:0]      wdata_d, wdata_q;
    logic [WIDTH-1:0] edges_d, edges_q;
    logic [WIDTH-1:0] level_d, level_q;
    logic             poll_tick;
    logic             in_idle;
    logic             trigger;
    logic             chk_hit;

    assign in_idle = (state_q == StIdle);
    assign trigger = irq | poll_tick;
    // The clear write must land in the same cycle the capture is seen, so it
    // bypasses the bus registers.
    assign chk_hit = (state_q == StChk) && (readdata[WIDTH-1:0] != '0);

    pio_poll_timer #(
        .POLL_CYCLES(POLL_CYCLES)
    ) u_poll_timer (
        .clk_i (clk),
        .rst_ni(reset_n),
        .en_i  (in_idle),
        .clr_i (!in_idle || trigger),
        .tick_o(poll_tick)
    );

    // Next-state and registered bus cycle for the state being entered.
    always_comb begin
        state_d = state_q;
        cs_d    = 1'b0;
        wen_d   = 1'b1;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        edges_d = edges_q;
        level_d = level_q;
        unique case (state_q)
            StInit: begin
                cs_d    = 1'b1;
                wen_d   = 1'b0;
                addr_d  = PIO_ADDR_IRQMASK;
                wdata_d = 32'(IRQ_MASK_INIT);
                state_d = StIdle;
            end
            StIdle: begin
                if (trigger) begin
                    cs_d    = 1'b1;
                    addr_d  = PIO_ADDR_EDGE;
                    state_d = StRdEdge;
                end
            end
            StRdEdge: state_d = StChk;
            StChk: begin
                if (chk_hit) begin
                    edges_d = readdata[WIDTH-1:0];
                    wdata_d = '0;
                    cs_d    = 1'b1;
                    addr_d  = PIO_ADDR_DATA;
                    state_d = StRdData;
                end else begin
                    state_d = StIdle;
                end
            end
            StRdData: state_d = StCap;
            StCap: begin
                level_d = readdata[WIDTH-1:0];
                state_d = StEmit;
            end
            StEmit: begin
                if (event_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    // State, bus and event registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StInit;
            cs_q    <= 1'b0;
            wen_q   <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            edges_q <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            edges_q <= edges_d;
            level_q <= level_d;
        end
    end

    assign chipselect  = cs_q | chk_hit;
    assign write_n     = wen_q & ~chk_hit;
    assign address     = chk_hit ? PIO_ADDR_EDGE : addr_q;
    assign writedata   = chk_hit ? 32'd0 : wdata_q;
    assign event_valid = (state_q == StEmit);
    assign event_edges = edges_q;
    assign event_level = level_q;

    logic unused_readdata;
    assign unused_readdata = ^readdata[31:WIDTH];

endmodule

// File: tb/tb_pio_event_servicer.sv
// Directed bench for pio_event_servicer with a small PIO slave model.
module tb_pio_event_servicer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        event_valid;
    logic        event_ready;
    logic [3:0]  event_edges;
    logic [3:0]  event_level;

    // PIO model state
    logic [3:0] edge_cap;
    logic [3:0] mask_q;
    logic [3:0] pio_data;
    logic [3:0] new_edges;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pio_event_servicer #(
        .WIDTH        (4),
        .IRQ_MASK_INIT(4'hF),
        .POLL_CYCLES  (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .event_valid(event_valid),
        .event_ready(event_ready),
        .event_edges(event_edges),
        .event_level(event_level)
    );

    // PIO slave: registered readdata, edge-capture clear wins over new edges.
    always @(posedge clk) begin
        if (!reset_n) begin
            edge_cap <= 4'h0;
            mask_q   <= 4'h0;
            readdata <= 32'h0;
        end else begin
            if (chipselect && !write_n && address == 2'd3) edge_cap <= 4'h0;
            else edge_cap <= edge_cap | new_edges;
            if (chipselect && !write_n && address == 2'd2) mask_q <= writedata[3:0];
            case (address)
                2'd0:    readdata <= {28'h0, pio_data};
                2'd2:    readdata <= {28'h0, mask_q};
                2'd3:    readdata <= {28'h0, edge_cap};
                default: readdata <= 32'h0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic cs, input logic wn, input logic [1:0] a);
        chk({tag, "_cs"}, 32'(chipselect), 32'(cs));
        chk({tag, "_wn"}, 32'(write_n), 32'(wn));
        chk({tag, "_addr"}, 32'(address), 32'(a));
    endtask

    // Release reset and expect the mask write then an idle bus; ends 2 cycles in.
    task automatic release_and_check_init(input string tag);
        reset_n = 1'b1;
        @(negedge clk);
        chk_bus({tag, "_wr"}, 1'b1, 1'b0, 2'd2);
        chk({tag, "_wdata"}, writedata, 32'hF);
        @(negedge clk);
        chk({tag, "_idle_cs"}, 32'(chipselect), 32'd0);
        chk({tag, "_idle_wn"}, 32'(write_n), 32'd1);
        chk({tag, "_hold_wdata"}, writedata, 32'hF);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (event_valid) break;
        end
        chk({tag, "_valid_seen"}, 32'(event_valid), 32'd1);
    endtask

    initial begin
        int reads;
        int writes;
        int valids;
        int bus_cnt;
        int drops;
        int changes;

        reset_n     = 1'b0;
        irq         = 1'b0;
        event_ready = 1'b0;
        new_edges   = 4'h0;
        pio_data    = 4'h0;
        repeat (3) @(negedge clk);

        // Reset values
        chk_bus("rst", 1'b0, 1'b1, 2'd0);
        chk("rst_wdata", writedata, 32'h0);
        chk("rst_valid", 32'(event_valid), 32'd0);
        chk("rst_edges", 32'(event_edges), 32'd0);
        chk("rst_level", 32'(event_level), 32'd0);
        release_and_check_init("init1");

        // irq-triggered service with timing
        new_edges = 4'b0101;
        pio_data  = 4'b1010;
        @(negedge clk);
        new_edges = 4'h0;
        irq       = 1'b1;
        @(negedge clk);
        irq = 1'b0;
        chk_bus("t2_rd3", 1'b1, 1'b1, 2'd3);
        @(negedge clk);
        chk_bus("t2_clr", 1'b1, 1'b0, 2'd3);
        chk("t2_clr_wdata", writedata, 32'h0);
        @(negedge clk);
        chk_bus("t2_rd0", 1'b1, 1'b1, 2'd0);
        @(negedge clk);
        chk("t2_cap_cs", 32'(chipselect), 32'd0);
        chk("t2_cap_valid", 32'(event_valid), 32'd0);
        chk("t2_pio_cleared", 32'(edge_cap), 32'd0);
        @(negedge clk);
        chk("t2_valid", 32'(event_valid), 32'd1);
        chk("t2_edges", 32'(event_edges), 32'h5);
        chk("t2_level", 32'(event_level), 32'hA);
        event_ready = 1'b1;
        @(negedge clk);
        event_ready = 1'b0;
        chk("t2_accepted", 32'(event_valid), 32'd0);

        // Persistent irq with empty capture: reads only, no event
        do_reset();
        release_and_check_init("init2");
        pio_data = 4'h0;
        irq      = 1'b1;
        reads = 0; writes = 0; valids = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (chipselect && write_n && address == 2'd3) reads++;
            if (chipselect && !write_n) writes++;
            if (event_valid) valids++;
        end
        irq = 1'b0;
        chk("t3_reads_ge3", 32'(reads >= 3), 32'd1);
        chk("t3_writes", 32'(writes), 32'd0);
        chk("t3_valids", 32'(valids), 32'd0);

        // Poll-triggered service after 8 idle cycles
        do_reset();
        release_and_check_init("init3");
        new_edges = 4'b0001;
        bus_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            new_edges = 4'h0;
            if (chipselect) bus_cnt++;
        end
        chk("t4_quiet", 32'(bus_cnt), 32'd0);
        @(negedge clk);
        chk_bus("t4_poll_rd3", 1'b1, 1'b1, 2'd3);
        wait_valid("t4", 10);
        chk("t4_edges", 32'(event_edges), 32'h1);
        chk("t4_level", 32'(event_level), 32'h0);
        event_ready = 1'b1;
        @(negedge clk);
        event_ready = 1'b0;

        // Backpressure: edges accumulate in PIO, delivered next service
        do_reset();
        release_and_check_init("init4");
        new_edges = 4'b0100;
        pio_data  = 4'b0011;
        @(negedge clk);
        new_edges = 4'h0;
        irq       = 1'b1;
        @(negedge clk);
        irq = 1'b0;
        wait_valid("t5a", 10);
        chk("t5a_edges", 32'(event_edges), 32'h4);
        chk("t5a_level", 32'(event_level), 32'h3);
        bus_cnt = 0; drops = 0; changes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            new_edges = (i == 2) ? 4'b0010 : 4'h0;
            if (chipselect) bus_cnt++;
            if (!event_valid) drops++;
            if (event_edges != 4'b0100 || event_level != 4'b0011) changes++;
        end
        chk("t5_stall_bus", 32'(bus_cnt), 32'd0);
        chk("t5_stall_drops", 32'(drops), 32'd0);
        chk("t5_stall_stable", 32'(changes), 32'd0);
        chk("t5_pio_pending", 32'(edge_cap), 32'h2);
        event_ready = 1'b1;
        @(negedge clk);
        event_ready = 1'b0;
        chk("t5_accepted", 32'(event_valid), 32'd0);
        irq = 1'b1;
        @(negedge clk);
        irq = 1'b0;
        wait_valid("t5b", 10);
        chk("t5b_edges", 32'(event_edges), 32'h2);
        chk("t5b_level", 32'(event_level), 32'h3);

        // Reset during EMIT discards the event and reruns INIT
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_valid", 32'(event_valid), 32'd0);
        chk("t6_cs", 32'(chipselect), 32'd0);
        chk("t6_edges", 32'(event_edges), 32'd0);
        @(negedge clk);
        release_and_check_init("init5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
